// File: rtl/parammod_pkg.sv
// Shared types and helpers for the packet-level round-robin stream multiplexer.
package parammod_pkg;

    typedef enum logic [0:0] {
        RRM_IDLE = 1'b0,
        RRM_LOCK = 1'b1
    } rrm_state_t;

    // Increment a port index, wrapping from ports-1 back to 0 for any port count.
    function automatic int unsigned rrm_wrap_inc(input int unsigned idx, input int unsigned ports);
        return (idx + 1 >= ports) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_prio_pick.sv
// Combinational round-robin picker: first set request at or after base, wrapping modulo PORT.
module rr_prio_pick #(
    parameter int PORT = 4,
    parameter int IDX  = (PORT > 1) ? $clog2(PORT) : 1
) (
    input  logic [PORT-1:0] req,
    input  logic [IDX-1:0]  base,
    output logic            found,
    output logic [IDX-1:0]  idx
);

    logic [2*PORT-1:0] req_x2;
    logic [PORT-1:0]   rot;
    logic [IDX-1:0]    off;
    logic [IDX:0]      sum;

    // NOTE: every signal written here gets a default first so no path leaves one unassigned (no latch).
    always_comb begin
        req_x2 = {req, req};
        // Rotating right by base puts request[base] at bit 0; base is always < PORT.
        rot    = PORT'(req_x2 >> base);
        found  = |rot;
        off    = '0;
        for (int i = PORT - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = IDX'(i);
            end
        end
        sum = {1'b0, off} + {1'b0, base};
        if (sum >= (IDX + 1)'(PORT)) begin
            sum = sum - (IDX + 1)'(PORT);
        end
        idx = sum[IDX-1:0];
    end

endmodule

// File: rtl/stream_rr_mux.sv
// N:1 round-robin valid/ready multiplexer that arbitrates only between packets;
// the winner owns the output until its last beat is accepted.
module stream_rr_mux
    import parammod_pkg::*;
#(
    parameter int PORT = 4,
    parameter int DATA = 32,
    parameter int IDX  = (PORT > 1) ? $clog2(PORT) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [PORT-1:0]      in_valid,
    input  logic [PORT-1:0]      in_last,
    input  logic [PORT*DATA-1:0] in_data,
    output logic [PORT-1:0]      in_ready,
    output logic                 out_valid,
    output logic                 out_last,
    output logic [DATA-1:0]      out_data,
    input  logic                 out_ready,
    output logic [IDX-1:0]       out_src,
    output logic                 out_first,
    output logic                 busy
);

    rrm_state_t     state_q, state_d;
    logic [IDX-1:0] r_ptr_q, r_ptr_d;
    logic [IDX-1:0] r_gnt_q, r_gnt_d;
    logic           r_first_q, r_first_d;

    logic           pick_found;
    logic [IDX-1:0] pick_idx;
    logic           handshake;

    logic [DATA-1:0] lane [PORT];

    for (genvar i = 0; i < PORT; i++) begin : g_lane
        assign lane[i] = in_data[i*DATA +: DATA];
    end

    rr_prio_pick #(
        .PORT (PORT),
        .IDX  (IDX)
    ) u_pick (
        .req   (in_valid),
        .base  (r_ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // The locked port is passed straight through; the other ports see ready=0.
    always_comb begin
        in_ready  = '0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        out_data  = lane[r_gnt_q];
        if (state_q == RRM_LOCK) begin
            out_valid         = in_valid[r_gnt_q];
            out_last          = in_last[r_gnt_q];
            in_ready[r_gnt_q] = out_ready;
        end
    end

    assign handshake = out_valid & out_ready;
    assign out_src   = r_gnt_q;
    assign out_first = r_first_q;
    assign busy      = (state_q == RRM_LOCK);

    always_comb begin
        state_d   = state_q;
        r_ptr_d   = r_ptr_q;
        r_gnt_d   = r_gnt_q;
        r_first_d = r_first_q;
        unique case (state_q)
            RRM_IDLE: begin
                if (pick_found) begin
                    r_gnt_d = pick_idx;
                    state_d = RRM_LOCK;
                end
            end
            RRM_LOCK: begin
                if (handshake) begin
                    if (out_last) begin
                        state_d   = RRM_IDLE;
                        r_ptr_d   = IDX'(rrm_wrap_inc(32'(r_gnt_q), PORT));
                        r_first_d = 1'b1;
                    end else begin
                        r_first_d = 1'b0;
                    end
                end
            end
            default: state_d = RRM_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= RRM_IDLE;
            r_ptr_q   <= '0;
            r_gnt_q   <= '0;
            r_first_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            r_ptr_q   <= r_ptr_d;
            r_gnt_q   <= r_gnt_d;
            r_first_q <= r_first_d;
        end
    end

endmodule

// File: tb/tb_stream_rr_mux.sv
// Self-checking bench for stream_rr_mux: directed scenarios plus randomized traffic
// compared against a packet-level round-robin reference model.
module tb_stream_rr_mux;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } beat_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         ordy;

    logic [3:0]   v, l, rdy;
    logic [127:0] d;
    logic         ovalid, olast, ofirst, obusy;
    logic [31:0]  odata;
    logic [1:0]   osrc;

    logic [2:0]   v3, l3, rdy3;
    logic [95:0]  d3;
    logic         ovalid3, olast3, ofirst3, obusy3;
    logic [31:0]  odata3;
    logic [1:0]   osrc3;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state (packet-level round robin).
    int m_ports;
    bit m_lock;
    int m_ptr;
    int m_gnt;
    bit m_first;

    beat_t src_q   [4][$];
    beat_t exp_seq [4][$];
    logic [3:0] stall;

    int          obs_src   [$];
    logic [31:0] obs_data  [$];
    logic        obs_last  [$];
    logic        obs_first [$];
    int          obs_cyc   [$];
    int          cyc;
    int          n_busy;

    stream_rr_mux #(.PORT(4), .DATA(32)) dut (
        .clk(clk), .reset(reset),
        .in_valid(v), .in_last(l), .in_data(d), .in_ready(rdy),
        .out_valid(ovalid), .out_last(olast), .out_data(odata), .out_ready(ordy),
        .out_src(osrc), .out_first(ofirst), .busy(obusy)
    );

    stream_rr_mux #(.PORT(3), .DATA(32)) dut3 (
        .clk(clk), .reset(reset),
        .in_valid(v3), .in_last(l3), .in_data(d3), .in_ready(rdy3),
        .out_valid(ovalid3), .out_last(olast3), .out_data(odata3), .out_ready(ordy),
        .out_src(osrc3), .out_first(ofirst3), .busy(obusy3)
    );

    always #5 clk = ~clk;

    task automatic present();
        v = '0; l = '0; d = '0;
        v3 = '0; l3 = '0; d3 = '0;
        for (int i = 0; i < m_ports; i++) begin
            if (src_q[i].size() > 0 && !stall[i]) begin
                if (m_ports == 4) begin
                    v[i] = 1'b1;
                    l[i] = src_q[i][0].last;
                    d[i*32 +: 32] = src_q[i][0].data;
                end else begin
                    v3[i] = 1'b1;
                    l3[i] = src_q[i][0].last;
                    d3[i*32 +: 32] = src_q[i][0].data;
                end
            end
        end
    endtask

    task automatic push_beat(input int p, input logic [31:0] data, input logic last);
        beat_t b;
        b.data = data;
        b.last = last;
        src_q[p].push_back(b);
        exp_seq[p].push_back(b);
    endtask

    task automatic clear_logs();
        obs_src.delete(); obs_data.delete(); obs_last.delete();
        obs_first.delete(); obs_cyc.delete();
        cyc = 0;
        n_busy = 0;
    endtask

    // One clock: compare DUT outputs against the model at negedge, then advance both.
    task automatic step();
        logic [3:0]  cur_v, cur_l, a_rdy, e_rdy, acc;
        logic [31:0] a_data, e_data;
        logic        a_valid, a_last, a_first, a_busy, e_valid;
        logic [1:0]  a_src;
        int          w;
        @(negedge clk);
        if (m_ports == 4) begin
            cur_v = v; cur_l = l; a_rdy = rdy; a_valid = ovalid; a_last = olast;
            a_data = odata; a_first = ofirst; a_busy = obusy; a_src = osrc;
            e_data = d[m_gnt*32 +: 32];
        end else begin
            cur_v = {1'b0, v3}; cur_l = {1'b0, l3}; a_rdy = {1'b0, rdy3}; a_valid = ovalid3;
            a_last = olast3; a_data = odata3; a_first = ofirst3; a_busy = obusy3; a_src = osrc3;
            e_data = d3[m_gnt*32 +: 32];
        end
        e_valid = m_lock && cur_v[m_gnt];
        e_rdy   = m_lock ? (4'(ordy) << m_gnt) : 4'b0;

        n_cmp++;
        if (a_busy !== m_lock) begin
            n_err++; $display("FAIL busy cyc%0d: got %b want %b", cyc, a_busy, m_lock);
        end
        n_cmp++;
        if (a_src !== 2'(m_gnt)) begin
            n_err++; $display("FAIL out_src cyc%0d: got %0d want %0d", cyc, a_src, m_gnt);
        end
        n_cmp++;
        if (int'(a_src) >= m_ports) begin
            n_err++; $display("FAIL out_src_range cyc%0d: got %0d want <%0d", cyc, a_src, m_ports);
        end
        n_cmp++;
        if (a_valid !== e_valid) begin
            n_err++; $display("FAIL out_valid cyc%0d: got %b want %b", cyc, a_valid, e_valid);
        end
        n_cmp++;
        if (a_rdy !== e_rdy) begin
            n_err++; $display("FAIL in_ready cyc%0d: got %b want %b", cyc, a_rdy, e_rdy);
        end
        n_cmp++;
        if (a_first !== m_first) begin
            n_err++; $display("FAIL out_first cyc%0d: got %b want %b", cyc, a_first, m_first);
        end
        if (e_valid) begin
            n_cmp++;
            if (a_data !== e_data || a_last !== cur_l[m_gnt]) begin
                n_err++;
                $display("FAIL out_beat cyc%0d: got %h/%b want %h/%b", cyc, a_data, a_last, e_data, cur_l[m_gnt]);
            end
        end

        if (a_busy) n_busy++;
        if (a_valid && ordy) begin
            obs_src.push_back(int'(a_src));
            obs_data.push_back(a_data);
            obs_last.push_back(a_last);
            obs_first.push_back(a_first);
            obs_cyc.push_back(cyc);
        end
        acc = a_rdy & cur_v;

        if (reset) begin
            m_lock = 0; m_ptr = 0; m_gnt = 0; m_first = 1;
        end else if (!m_lock) begin
            for (int k = 0; k < m_ports; k++) begin
                w = (m_ptr + k) % m_ports;
                if (cur_v[w]) begin
                    m_lock = 1;
                    m_gnt  = w;
                    break;
                end
            end
        end else if (cur_v[m_gnt] && ordy) begin
            if (cur_l[m_gnt]) begin
                m_lock  = 0;
                m_ptr   = (m_gnt + 1) % m_ports;
                m_first = 1;
            end else begin
                m_first = 0;
            end
        end

        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (acc[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        end
        cyc++;
        present();
    endtask

    task automatic apply_reset(input int ports);
        m_ports = ports;
        reset = 1'b1;
        ordy  = 1'b0;
        stall = '0;
        for (int i = 0; i < 4; i++) begin
            src_q[i].delete();
            exp_seq[i].delete();
        end
        present();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        m_lock = 0; m_ptr = 0; m_gnt = 0; m_first = 1;
        clear_logs();
    endtask

    task automatic test_reset();
        apply_reset(4);
        @(negedge clk);
        n_cmp++;
        if (obusy !== 1'b0 || obusy3 !== 1'b0) begin
            n_err++; $display("FAIL reset_busy: got %b/%b want 0/0", obusy, obusy3);
        end
        n_cmp++;
        if (rdy !== 4'b0 || ovalid !== 1'b0) begin
            n_err++; $display("FAIL reset_ready_valid: got %b/%b want 0000/0", rdy, ovalid);
        end
        n_cmp++;
        if (osrc !== 2'd0 || osrc3 !== 2'd0) begin
            n_err++; $display("FAIL reset_src: got %0d/%0d want 0/0", osrc, osrc3);
        end
        n_cmp++;
        if (ofirst !== 1'b1) begin
            n_err++; $display("FAIL reset_first: got %b want 1", ofirst);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_beat();
        apply_reset(4);
        ordy = 1'b1;
        push_beat(0, 32'hA000_0000, 1'b1);
        push_beat(0, 32'hA000_0001, 1'b1);
        push_beat(2, 32'hC000_0000, 1'b1);
        present();
        repeat (6) step();
        n_cmp++;
        if (obs_src.size() != 3) begin
            n_err++; $display("FAIL single_count: got %0d want 3", obs_src.size());
        end else begin
            n_cmp++;
            if (obs_src[0] != 0 || obs_src[1] != 2 || obs_src[2] != 0) begin
                n_err++; $display("FAIL single_order: got %0d,%0d,%0d want 0,2,0", obs_src[0], obs_src[1], obs_src[2]);
            end
            n_cmp++;
            if (obs_cyc[0] != 1 || obs_cyc[1] != 3 || obs_cyc[2] != 5) begin
                n_err++; $display("FAIL single_bubble: got %0d,%0d,%0d want 1,3,5", obs_cyc[0], obs_cyc[1], obs_cyc[2]);
            end
            n_cmp++;
            if (obs_first[0] !== 1'b1 || obs_first[1] !== 1'b1 || obs_first[2] !== 1'b1) begin
                n_err++; $display("FAIL single_first: got %b%b%b want 111", obs_first[0], obs_first[1], obs_first[2]);
            end
        end
    endtask

    task automatic test_multi_beat_lock();
        int want [5] = '{0, 1, 1, 1, 3};
        apply_reset(4);
        ordy = 1'b1;
        push_beat(0, 32'h0000_00A0, 1'b1);
        push_beat(0, 32'h0000_00A1, 1'b1);
        for (int k = 0; k < 3; k++) push_beat(1, 32'h1000 + k, (k == 2));
        push_beat(3, 32'h3000_0000, 1'b1);
        present();
        repeat (8) step();
        n_cmp++;
        if (obs_src.size() != 5) begin
            n_err++; $display("FAIL lock_count: got %0d want 5", obs_src.size());
        end else begin
            for (int k = 0; k < 5; k++) begin
                n_cmp++;
                if (obs_src[k] != want[k]) begin
                    n_err++; $display("FAIL lock_src[%0d]: got %0d want %0d", k, obs_src[k], want[k]);
                end
            end
            n_cmp++;
            if (obs_data[3] !== 32'h1002 || obs_last[3] !== 1'b1) begin
                n_err++; $display("FAIL lock_last_beat: got %h/%b want 00001002/1", obs_data[3], obs_last[3]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] want [4] = '{32'hD0, 32'hD1, 32'hD2, 32'hD3};
        apply_reset(4);
        for (int k = 0; k < 4; k++) push_beat(2, want[k], (k == 3));
        ordy = 1'b1;
        present();
        step();
        for (int k = 0; k < 9; k++) begin
            ordy = k[0];
            step();
        end
        n_cmp++;
        if (n_busy != 8) begin
            n_err++; $display("FAIL bp_lock_cycles: got %0d want 8", n_busy);
        end
        n_cmp++;
        if (obs_data.size() != 4) begin
            n_err++; $display("FAIL bp_beat_count: got %0d want 4", obs_data.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                n_cmp++;
                if (obs_data[k] !== want[k] || obs_src[k] != 2) begin
                    n_err++; $display("FAIL bp_beat[%0d]: got %h@%0d want %h@2", k, obs_data[k], obs_src[k], want[k]);
                end
            end
        end
    endtask

    task automatic test_wrap_port3();
        int want [5] = '{0, 1, 2, 0, 1};
        apply_reset(3);
        ordy = 1'b1;
        for (int p = 0; p < 3; p++) begin
            push_beat(p, 32'h5000 + p, 1'b1);
            push_beat(p, 32'h5100 + p, 1'b1);
        end
        present();
        repeat (10) step();
        n_cmp++;
        if (obs_src.size() != 5) begin
            n_err++; $display("FAIL wrap_count: got %0d want 5", obs_src.size());
        end else begin
            for (int k = 0; k < 5; k++) begin
                n_cmp++;
                if (obs_src[k] != want[k]) begin
                    n_err++; $display("FAIL wrap_src[%0d]: got %0d want %0d", k, obs_src[k], want[k]);
                end
            end
        end
    endtask

    task automatic test_valid_gap();
        int busy_before;
        apply_reset(4);
        ordy = 1'b1;
        for (int k = 0; k < 4; k++) push_beat(0, 32'hE0 + k, (k == 3));
        push_beat(1, 32'hF0, 1'b1);
        present();
        repeat (3) step();
        stall[0] = 1'b1;
        present();
        busy_before = n_busy;
        repeat (2) step();
        n_cmp++;
        if (n_busy - busy_before != 2 || obs_src.size() != 2) begin
            n_err++; $display("FAIL gap_hold: got busy+%0d beats %0d want busy+2 beats 2", n_busy - busy_before, obs_src.size());
        end
        stall[0] = 1'b0;
        present();
        repeat (4) step();
        n_cmp++;
        if (obs_src.size() != 5 || obs_src[4] != 1 || obs_src[3] != 0) begin
            n_err++; $display("FAIL gap_resume: got %0d beats want 5 ending 0,1", obs_src.size());
        end
    endtask

    task automatic test_reset_mid_packet();
        apply_reset(4);
        ordy = 1'b1;
        push_beat(1, 32'h11, 1'b1);
        present();
        repeat (2) step();
        for (int k = 0; k < 4; k++) push_beat(0, 32'h20 + k, (k == 3));
        present();
        repeat (3) step();
        ordy  = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        src_q[0].delete();
        present();
        @(negedge clk);
        n_cmp++;
        if (obusy !== 1'b0 || rdy !== 4'b0 || osrc !== 2'd0) begin
            n_err++; $display("FAIL rst_mid: got busy %b ready %b src %0d want 0 0000 0", obusy, rdy, osrc);
        end
        @(posedge clk);
        #1;
        clear_logs();
        push_beat(0, 32'h30, 1'b1);
        push_beat(3, 32'h33, 1'b1);
        ordy = 1'b1;
        present();
        repeat (2) step();
        n_cmp++;
        if (obs_src.size() != 1 || obs_src[0] != 0) begin
            n_err++; $display("FAIL rst_next_grant: got %0d beats first src %0d want 1 beat src 0",
                              obs_src.size(), (obs_src.size() > 0) ? obs_src[0] : -1);
        end
    endtask

    task automatic test_random();
        int pkt_left [4];
        int got;
        beat_t e;
        apply_reset(4);
        for (int i = 0; i < 4; i++) pkt_left[i] = 0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (pkt_left[i] == 0 && $urandom_range(3) == 0) pkt_left[i] = $urandom_range(4, 1);
                if (pkt_left[i] > 0 && src_q[i].size() < 2 && $urandom_range(2) != 0) begin
                    push_beat(i, $urandom, (pkt_left[i] == 1));
                    pkt_left[i]--;
                end
            end
            ordy = ($urandom_range(3) != 0);
            present();
            step();
        end
        got = 0;
        for (int k = 0; k < obs_src.size(); k++) begin
            n_cmp++;
            if (exp_seq[obs_src[k]].size() == 0) begin
                n_err++; $display("FAIL rand_extra_beat: port %0d got %h want none", obs_src[k], obs_data[k]);
            end else begin
                e = exp_seq[obs_src[k]].pop_front();
                if (obs_data[k] !== e.data || obs_last[k] !== e.last) begin
                    n_err++;
                    $display("FAIL rand_order port%0d: got %h/%b want %h/%b", obs_src[k], obs_data[k], obs_last[k], e.data, e.last);
                end
                got++;
            end
        end
        n_cmp++;
        if (got < 50) begin
            n_err++; $display("FAIL rand_throughput: got %0d beats want >=50", got);
        end
    endtask

    initial begin
        m_ports = 4;
        reset   = 1'b1;
        ordy    = 1'b0;
        stall   = '0;
        present();
        test_reset();
        test_single_beat();
        test_multi_beat_lock();
        test_backpressure();
        test_wrap_port3();
        test_valid_gap();
        test_reset_mid_packet();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
